// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: ping-pong frame collector feeding the 256-point FFT.
// Samples arrive over a valid/ready handshake and fill one of two banks; a full bank is
// presented on time_samples with a one-cycle start pulse and held until done is seen.
// Optional build macro: FFT_FRAME_DROP_CNT_EN enables the saturating 16-bit drop counter.
module fft_frame_buffer #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned N     = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    start,
  input  logic                    done,
  output logic signed [WIDTH-1:0] time_samples [0:N-1],
  output logic                    busy,
  output logic                    overrun,
  output logic [15:0]             drop_count
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait
  } state_e;

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] bank_q [2][N];
  logic signed [WIDTH-1:0] bank_d [2][N];
  logic [1:0]              full_q, full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [IdxW-1:0]         wr_idx_q, wr_idx_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic accept;
  logic drop;
  logic release_frame;

  // Ready is forced low while in reset so nothing is handshaken during that time.
  assign sample_ready = rst & ~full_q[wr_bank_q];
  assign accept       = sample_valid & sample_ready;
  assign drop         = sample_valid & ~sample_ready;

  // Presentation FSM: wait for the oldest bank to fill, pulse start, hold until done.
  always_comb begin
    state_d       = state_q;
    rd_bank_d     = rd_bank_q;
    release_frame = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (done) begin
          release_frame = 1'b1;
          rd_bank_d     = ~rd_bank_q;
          state_d       = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    start_d = (state_d == StStart);
    busy_d  = (state_d == StWait);
  end

  // Write side: store accepted sample, mark bank full and switch banks at end of frame.
  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    overrun_d = overrun_q | drop;
    // Release and fill never target the same bank: a presented bank is full, so unwritable.
    if (release_frame) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (accept) begin
      bank_d[wr_bank_q][wr_idx_q] = sample_in;
      if (wr_idx_q == LastIdx) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + IdxW'(1);
      end
    end
  end

  // State, pointer, flag and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame storage; every location clears on reset so a partial frame is discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      bank_q <= bank_d;
    end
  end

  // The presented frame is read straight out of storage.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      time_samples[i] = bank_q[rd_bank_q][i];
    end
  end

  assign start   = start_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

`ifdef FFT_FRAME_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of discarded samples.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register; clears only on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule
